// File: rtl/wb_prospect_buffer.sv
// ---------------------------------------------------------------------------
// wb_prospect_buffer
//
// Circular queue of pending writebacks.  Each entry carries 64 bits of result
// data and eight 16-bit tags, one per byte.  The oldest entry is presented on
// the out_* handshake.  Every slot is also exposed on the prospective_* ports
// so a downstream bypass mux can forward bytes before the writeback happens.
//
// A tag that is re-written by a younger entry is "shadowed": it is hidden on
// the prospective_ptc port of the older entry.  As a result, every nonzero
// tag exposed across all slots is unique, and the bypass mux never sees two
// drivers for the same tag.  The out_ptc port still shows the full original
// tag word, because the writeback itself must commit every byte.
//
// Ports
//   clk              : clock; all state updates on the rising edge
//   clr              : asynchronous active-low reset
//   in_valid/ready   : enqueue handshake; in_ready = not full
//   in_data          : 64-bit result, byte b at [8b+7:8b]
//   in_ptc           : 8 x 16-bit tags, chunk b at [16b+15:16b]; 0 = byte unused
//   out_valid/ready  : dequeue handshake for the oldest entry
//   out_data/out_ptc : data and full original tags of the oldest entry
//   flush            : synchronously empty the buffer; overrides both handshakes
//   prospective_data : stored data of physical slot k at [64k+63:64k]
//   prospective_ptc  : live tags of slot k at [128k+127:128k]; dead chunks = 0
//   count            : number of occupied entries
// ---------------------------------------------------------------------------
module wb_prospect_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    input  logic [127:0]         in_ptc,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [63:0]          out_data,
    output logic [127:0]         out_ptc,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [DEPTH*64-1:0]  prospective_data,
    output logic [DEPTH*128-1:0] prospective_ptc,
    output logic [PTR_W:0]       count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    // Slot storage.  Contents need no reset: a slot is only observable through
    // its valid/live bits, and those are cleared by reset and flush.
    logic [63:0]  data_mem [DEPTH];
    logic [127:0] ptc_mem  [DEPTH];

    logic [PTR_W-1:0]      wp_reg, wp_next;
    logic [PTR_W-1:0]      rp_reg, rp_next;
    logic [PTR_W:0]        count_reg, count_next;
    logic [DEPTH-1:0]      valid_reg, valid_next;
    logic [DEPTH-1:0][7:0] live_reg, live_next;
    logic [DEPTH-1:0][7:0] shadow_hit;
    logic [7:0]            in_live;
    logic                  enq;
    logic                  deq;

    // Handshakes look only at registered state, so a dequeue in the same
    // cycle never opens room for an enqueue into a full buffer.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign out_data  = data_mem[rp_reg];
    assign out_ptc   = ptc_mem[rp_reg];
    assign count     = count_reg;

    assign enq = in_valid & in_ready;
    assign deq = out_valid & out_ready;

    genvar gi, gb, gc;
    generate
        for (gb = 0; gb < 8; gb++) begin : g_in_live
            assign in_live[gb] = |in_ptc[16*gb +: 16];
        end

        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign prospective_data[64*gi +: 64] = data_mem[gi];

            for (gb = 0; gb < 8; gb++) begin : g_chunk
                // Stored chunk gb of slot gi matches some nonzero lane of the
                // incoming tag word, in any position.
                logic [7:0] lane_eq;
                for (gc = 0; gc < 8; gc++) begin : g_lane
                    assign lane_eq[gc] = in_live[gc] &&
                        (in_ptc[16*gc +: 16] == ptc_mem[gi][16*gb +: 16]);
                end
                assign shadow_hit[gi][gb] = |lane_eq;

                assign prospective_ptc[128*gi + 16*gb +: 16] =
                    (valid_reg[gi] && live_reg[gi][gb]) ? ptc_mem[gi][16*gb +: 16] : 16'h0000;
            end
        end
    endgenerate

    always_comb begin
        wp_next    = wp_reg;
        rp_next    = rp_reg;
        count_next = count_reg;
        valid_next = valid_reg;
        live_next  = live_reg;

        // Youngest writer wins: older entries lose any tag the new entry
        // also writes.  The slot being filled is never valid here.
        if (enq) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (PTR_W'(k) != wp_reg) begin
                    live_next[k] = live_reg[k] & ~shadow_hit[k];
                end
            end
        end

        if (deq) begin
            valid_next[rp_reg] = 1'b0;
            live_next[rp_reg]  = '0;
            rp_next            = rp_reg + 1'b1;
        end

        if (enq) begin
            valid_next[wp_reg] = 1'b1;
            live_next[wp_reg]  = in_live;
            wp_next            = wp_reg + 1'b1;
        end

        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            live_reg  <= '0;
        end else if (flush) begin
            wp_reg    <= '0;
            rp_reg    <= '0;
            count_reg <= '0;
            valid_reg <= '0;
            live_reg  <= '0;
        end else begin
            wp_reg    <= wp_next;
            rp_reg    <= rp_next;
            count_reg <= count_next;
            valid_reg <= valid_next;
            live_reg  <= live_next;
        end
    end

    // Flush also suppresses the write so prospective_data does not change
    // for a handshake that is being discarded.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            data_mem[wp_reg] <= in_data;
            ptc_mem[wp_reg]  <= in_ptc;
        end
    end

endmodule

// File: tb/tb_wb_prospect_buffer.sv
module tb_wb_prospect_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic                 clk = 1'b0;
    logic                 clr = 1'b0;
    logic                 in_valid = 1'b0;
    logic [63:0]          in_data = '0;
    logic [127:0]         in_ptc = '0;
    logic                 out_ready = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic [63:0]          out_data;
    logic [127:0]         out_ptc;
    logic [DEPTH*64-1:0]  prospective_data;
    logic [DEPTH*128-1:0] prospective_ptc;
    logic [PTR_W:0]       count;

    int checks = 0;
    int errors = 0;

    wb_prospect_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .clr              (clr),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ptc           (in_ptc),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ptc          (out_ptc),
        .out_ready        (out_ready),
        .flush            (flush),
        .prospective_data (prospective_data),
        .prospective_ptc  (prospective_ptc),
        .count            (count)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of entries, each remembering which physical slot
    // it landed in (enqueue index since the last flush/reset, modulo DEPTH).
    typedef struct {
        int           slot;
        logic [63:0]  data;
        logic [127:0] ptc;
        logic [7:0]   live;
    } ent_t;

    ent_t q[$];
    int   next_slot = 0;
    logic [63:0] got[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_slot = 0;
    endtask

    task automatic model_step(input bit iv, input logic [63:0] d, input logic [127:0] p,
                              input bit ordy, input bit fl);
        bit   enq_ok;
        bit   deq_ok;
        ent_t e;
        enq_ok = iv && (q.size() != DEPTH) && !fl;
        deq_ok = ordy && (q.size() != 0) && !fl;
        if (fl) begin
            model_reset();
            return;
        end
        if (deq_ok) void'(q.pop_front());
        if (enq_ok) begin
            foreach (q[i])
                for (int b = 0; b < 8; b++)
                    for (int c = 0; c < 8; c++)
                        if (p[16*c +: 16] != 16'h0 && p[16*c +: 16] == q[i].ptc[16*b +: 16])
                            q[i].live[b] = 1'b0;
            e.slot = next_slot;
            e.data = d;
            e.ptc  = p;
            for (int b = 0; b < 8; b++) e.live[b] = (p[16*b +: 16] != 16'h0);
            q.push_back(e);
            next_slot = (next_slot + 1) % DEPTH;
        end
    endtask

    task automatic check_all();
        logic [511:0] exp_pptc;
        int dups;
        exp_pptc = '0;
        dups = 0;
        chk("count", count, q.size());
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_ptc", out_ptc, q[0].ptc);
        end
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++)
                if (q[i].live[b]) exp_pptc[128*q[i].slot + 16*b +: 16] = q[i].ptc[16*b +: 16];
            chk("pdata", prospective_data[64*q[i].slot +: 64], q[i].data);
        end
        chk("pptc", prospective_ptc, exp_pptc);
        for (int a = 0; a < 8*DEPTH; a++)
            for (int b = a + 1; b < 8*DEPTH; b++)
                if (prospective_ptc[16*a +: 16] != 16'h0 &&
                    prospective_ptc[16*a +: 16] == prospective_ptc[16*b +: 16])
                    dups++;
        chk("unique_tags", dups, 0);
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit iv, input logic [63:0] d, input logic [127:0] p,
                        input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        in_ptc    = p;
        out_ready = ordy;
        flush     = fl;
        model_step(iv, d, p, ordy, fl);
        @(posedge clk);
        #1;
        $display("step iv=%0d ordy=%0d fl=%0d data=%0h ptc=%0h -> count=%0d",
                 iv, ordy, fl, d, p, count);
        check_all();
    endtask

    function automatic logic [127:0] rand_ptc();
        logic [127:0] p;
        logic [7:0]   used;
        int           t;
        p = '0;
        used = '0;
        for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 1) == 1) begin
                t = $urandom_range(1, 7);
                if (!used[t]) begin
                    used[t] = 1'b1;
                    p[16*b +: 16] = 16'(t * 257);
                end
            end
        end
        return p;
    endfunction

    initial begin
        // Reset state.
        #3;
        check_all();
        chk("reset_pptc", prospective_ptc, '0);
        @(negedge clk);
        clr = 1'b1;

        // Single enqueue into empty buffer, on the first edge after reset.
        step(1, 64'h11, 128'h1, 0, 0);
        chk("r034_out_valid", out_valid, 1'b1);
        chk("r034_count", count, 1);
        chk("r034_pptc", prospective_ptc, 512'h1);

        // Shadowing: B rewrites A's tag in a different lane.
        step(0, 64'h0, 128'h0, 0, 1);
        step(1, 64'hA, 128'h5, 0, 0);
        step(1, 64'hB, 128'h5 << 48, 0, 0);
        chk("r035_slot0_chunk0", prospective_ptc[15:0], 16'h0);
        chk("r035_slot1_chunk3", prospective_ptc[128+48 +: 16], 16'h5);
        chk("r035_out_ptc", out_ptc, 128'h5);

        // Fill, overflow attempt, dequeue with simultaneous enqueue when full.
        step(1, 64'hC, 128'h9 << 16, 0, 0);
        step(1, 64'hD, 128'hA << 32, 0, 0);
        chk("r036_in_ready", in_ready, 1'b0);
        chk("r036_count4", count, 4);
        step(1, 64'hE, 128'h77, 0, 0);
        chk("r036_ignored", count, 4);
        step(1, 64'hE, 128'h77, 1, 0);
        chk("r036_count3", count, 3);
        chk("r036_front", out_data, 64'hB);

        // Six enqueues with interleaved dequeues; wp wraps, order preserved.
        step(0, 64'h0, 128'h0, 0, 1);
        got.delete();
        for (int i = 0; i < 6; i++) begin
            if (out_valid && i >= 2) got.push_back(out_data);
            step(1, 64'(100 + i), 128'(i + 1), i >= 2, 0);
        end
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            if (out_valid) got.push_back(out_data);
            step(0, 64'h0, 128'h0, 1, 0);
        end
        chk("r037_drained", count, 0);
        chk("r037_n", got.size(), 6);
        foreach (got[j]) chk("r037_order", got[j], 64'(100 + j));

        // Flush wins over both handshakes.
        step(1, 64'h21, 128'h21, 0, 0);
        step(1, 64'h22, 128'h22, 0, 0);
        step(1, 64'h23, 128'h23, 1, 1);
        chk("r038_count", count, 0);
        chk("r038_out_valid", out_valid, 1'b0);
        chk("r038_pptc", prospective_ptc, '0);

        // Asynchronous reset between edges.
        step(1, 64'h31, 128'h31, 0, 0);
        step(1, 64'h32, 128'h32, 0, 0);
        step(1, 64'h33, 128'h33, 0, 0);
        in_valid = 1'b0;
        #2;
        clr = 1'b0;
        #1;
        model_reset();
        chk("r039_count", count, 0);
        chk("r039_in_ready", in_ready, 1'b1);
        chk("r039_out_valid", out_valid, 1'b0);
        chk("r039_pptc", prospective_ptc, '0);
        clr = 1'b1;
        step(1, 64'h41, 128'h41, 0, 0);
        chk("r033_first_edge", count, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, rand_ptc(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_prospect_buffer.md
WB_PROSPECT_BUFFER -- requirements
Module: wb_prospect_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of pending-writeback entries; it SHALL equal the consumer's NUM_PROSPECTS.
REQ-002 SHALL have parameter PTR_W, default 2, giving the pointer width; DEPTH SHALL equal 2**PTR_W.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, width 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, width 1: an enqueue request.
REQ-006 SHALL have port in_data, input, width 64: result bytes; byte b is [8b+7:8b].
REQ-007 SHALL have port in_ptc, input, width 128: one 16-bit tag per byte; chunk b is [16b+15:16b]; an all-zero chunk means that byte is not written.
REQ-008 SHALL have port in_ready, output, width 1: high when not full.
REQ-009 SHALL have port out_valid, output, width 1: the oldest entry is present.
REQ-010 SHALL have port out_data, output, width 64: data of the oldest entry.
REQ-011 SHALL have port out_ptc, output, width 128: the full original ptc of the oldest entry.
REQ-012 SHALL have port out_ready, input, width 1: the writeback consumer accepts the oldest entry.
REQ-013 SHALL have port flush, input, width 1: synchronously discard all entries.
REQ-014 SHALL have port prospective_data, output, width DEPTH*64: the data of physical slot k, at [64k+63:64k].
REQ-015 SHALL have port prospective_ptc, output, width DEPTH*128: the exposed ptc of slot k, at [128k+127:128k].
REQ-016 SHALL have port count, output, width PTR_W+1: the number of occupied entries.

Function
REQ-017 SHALL store entries in a circular buffer with write pointer wp and read pointer rp, each PTR_W bits wide, plus the count register.
REQ-018 SHALL keep, per slot, a valid bit and an 8-bit live mask, one bit per byte chunk.
REQ-019 SHALL accept an enqueue when in_valid and in_ready are both high at a clock edge; the entry is written to slot wp, wp increments modulo DEPTH, the slot becomes valid, and live[b] is set to (in_ptc chunk b != 0).
REQ-020 SHALL drive in_ready = (count != DEPTH), registered state only; a dequeue in the same cycle SHALL NOT allow an enqueue when full.
REQ-021 SHALL perform a dequeue when out_valid and out_ready are both high; slot rp is invalidated, its live mask is cleared, and rp increments modulo DEPTH.
REQ-022 SHALL drive out_valid = (count != 0), and out_data and out_ptc from slot rp; the outputs are don't-care when out_valid is low.
REQ-023 SHALL update count by +1 on an enqueue only, by -1 on a dequeue only, and leave it unchanged when both occur or neither occurs.
REQ-024 SHALL apply shadowing on each accepted enqueue: every live chunk of any other valid slot whose 16-bit value equals any nonzero chunk of in_ptc (any lane) has its live bit cleared at the same edge, so the youngest writer wins.
REQ-025 SHALL, as a shadowing boundary, exclude the slot being dequeued in the same cycle from the comparison, which has no effect; duplicate nonzero chunks within a single in_ptc are the producer's error and are not checked.
REQ-026 SHALL expose, for each slot k and chunk b, prospective_ptc chunk = (valid[k] & live[k][b]) ? stored chunk : 16'h0000, and prospective_data = stored data unconditionally.
REQ-027 SHALL guarantee, as a consequence of REQ-024 and REQ-026, that no two exposed nonzero prospective_ptc chunks are equal, so the bypass tristate mux never contends.
REQ-028 SHALL have no bypass-through path: an entry enqueued at edge N is visible on the out_* and prospective_* ports only after edge N.
REQ-029 SHALL give flush priority over an enqueue and a dequeue in the same cycle: wp=rp=0, count=0, and all valid and live bits cleared; the in/out handshakes in that cycle have no effect.
REQ-030 SHALL wrap wp and rp from DEPTH-1 to 0 with no bubble.

Reset
REQ-031 SHALL, while clr=0 and independent of clk, hold wp=0, rp=0, count=0, all valid and live bits=0, in_ready=1, out_valid=0, and every prospective_ptc chunk=0.
REQ-032 SHALL, if reset asserts mid-operation, discard all entries with no partial writeback; stored data contents need not be cleared.
REQ-033 SHALL accept an enqueue on the first rising edge after clr deasserts.

Verification
REQ-034 SHALL be checked: enqueue ptc chunk0=16'h0001, data 64'h11 into an empty buffer -> next cycle out_valid=1, count=1, prospective_ptc[15:0]=16'h0001, and all other chunks 0.
REQ-035 SHALL be checked: enqueue A (chunk0=16'h0005), then B (chunk3=16'h0005) -> slot0 chunk0 is exposed as 0, slot1 chunk3 as 16'h0005, and out_ptc still shows A's full 16'h0005.
REQ-036 SHALL be checked: 4 enqueues with out_ready=0 -> in_ready=0 and count=4; a 5th in_valid is ignored; a dequeue with simultaneous in_valid -> count=3 and the 5th is not accepted in that cycle.
REQ-037 SHALL be checked: 6 enqueues with interleaved dequeues -> wp wraps 3->0, and out_data order equals enqueue order.
REQ-038 SHALL be checked: flush asserted together with in_valid and out_ready while count=2 -> next cycle count=0, out_valid=0, and all prospective_ptc=0.
REQ-039 SHALL be checked: clr pulsed low between edges while count=3 -> count=0 and in_ready=1 immediately, without waiting for clk.
